// File: rtl/cv32e40s_pkg.sv
// Shared types and limits for the instruction-fetch OBI sequencer.
package cv32e40s_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } ifetch_seq_state_e;

    localparam int IFETCH_SEQ_MAX_OUTSTANDING_LIMIT = 7;

    function automatic int ifetch_cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/cv32e40s_ifetch_outstanding_cnt.sv
// Generic up/down counter with a load port and a zero flag; load has priority.
module cv32e40s_ifetch_outstanding_cnt
    import cv32e40s_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (load_i) begin
            w_cnt_d = load_val_i;
        end else begin
            w_cnt_d = r_cnt + W'(inc_i) - W'(dec_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign cnt_o  = r_cnt;
    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/cv32e40s_ifetch_obi_sequencer.sv
// Fetch request scheduler in front of the instruction OBI adapter; drops responses of pre-kill fetches.
// Optional feature macro: CV32E40S_IFETCH_DISCARD_CNT_EN (saturating dropped-response counter).
module cv32e40s_ifetch_obi_sequencer
    import cv32e40s_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_dbg_i,
    input  logic        kill_i,
    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    output logic        trans_dbg_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        out_valid_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o,
    output logic        busy_o,
    output logic [15:0] discard_cnt_o
);

    localparam int CW = ifetch_cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > IFETCH_SEQ_MAX_OUTSTANDING_LIMIT) begin : g_bad_max
        $error("MAX_OUTSTANDING out of range 1..%0d", IFETCH_SEQ_MAX_OUTSTANDING_LIMIT);
    end

    ifetch_seq_state_e r_state;

    logic [CW-1:0] w_cnt;
    logic          w_cnt_zero;
    logic [CW-1:0] w_dcnt;
    logic          w_dcnt_zero;
    logic [CW-1:0] w_dcnt_d;
    logic [CW-1:0] w_kill_val;
    logic          w_accept;
    logic          w_dcnt_dec;

    // Issue is combinational; a slot freed by a same-cycle response is not reused until next cycle.
    assign trans_valid_o = fetch_valid_i && !kill_i && (w_cnt < MAX_C);
    assign w_accept      = trans_valid_o && trans_ready_i;
    assign fetch_ready_o = w_accept;
    assign trans_addr_o  = {fetch_addr_i[31:2], 2'b00};
    assign trans_dbg_o   = fetch_dbg_i;

    assign out_valid_o = resp_valid_i && w_dcnt_zero && !kill_i;
    assign out_rdata_o = resp_rdata_i;
    assign out_err_o   = resp_err_i;
    assign busy_o      = !w_cnt_zero;

    // Everything in flight at kill time is stale, minus a response retiring in that same cycle.
    assign w_kill_val = w_cnt - CW'(resp_valid_i);
    assign w_dcnt_dec = resp_valid_i && (r_state == DISCARD);
    assign w_dcnt_d   = kill_i ? w_kill_val : (w_dcnt - CW'(w_dcnt_dec));

    cv32e40s_ifetch_outstanding_cnt #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (w_accept),
        .dec_i      (resp_valid_i),
        .load_i     (1'b0),
        .load_val_i ({CW{1'b0}}),
        .cnt_o      (w_cnt),
        .zero_o     (w_cnt_zero)
    );

    cv32e40s_ifetch_outstanding_cnt #(
        .W (CW)
    ) u_dcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (1'b0),
        .dec_i      (w_dcnt_dec),
        .load_i     (kill_i),
        .load_val_i (w_kill_val),
        .cnt_o      (w_dcnt),
        .zero_o     (w_dcnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (kill_i && (w_dcnt_d != '0)) begin
                        r_state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (w_dcnt_d == '0) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef CV32E40S_IFETCH_DISCARD_CNT_EN
    logic        w_drop;
    logic [15:0] r_discard_cnt;

    assign w_drop = resp_valid_i && !out_valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discard_cnt <= 16'h0000;
        end else if (w_drop && (r_discard_cnt != 16'hFFFF)) begin
            r_discard_cnt <= r_discard_cnt + 16'd1;
        end
    end

    assign discard_cnt_o = r_discard_cnt;
`else
    assign discard_cnt_o = 16'h0000;
`endif

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) w_cnt <= MAX_C);
    a_no_resp_idle : assert property (@(posedge clk) disable iff (!rst_n) resp_valid_i |-> !w_cnt_zero);
    a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n) trans_valid_o |-> (trans_addr_o[1:0] == 2'b00));

endmodule

// File: doc/cv32e40s_ifetch_obi_sequencer.md
# cv32e40s_ifetch_obi_sequencer

Fetch-side scheduler between the prefetcher and the instruction OBI adapter. It issues fetch requests onto the adapter's transaction interface, limits outstanding OBI transactions to a configurable maximum, and tracks in-flight responses. On a kill (branch or flush) it discards responses belonging to transactions that were already in flight, so only post-kill data reaches the prefetch buffer.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions; legal range 1..7.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_valid_i  in  1  prefetcher requests a fetch
- fetch_ready_o  out  1  fetch accepted this cycle; equals trans_valid_o && trans_ready_i
- fetch_addr_i  in  32  word address; bits [1:0] are ignored and driven 0 downstream
- fetch_dbg_i  in  1  debug-mode fetch
- kill_i  in  1  discard all in-flight transactions
- trans_valid_o  out  1  transaction request to the OBI adapter
- trans_ready_i  in  1  OBI adapter accepts the request
- trans_addr_o  out  32  {fetch_addr_i[31:2], 2'b00}
- trans_dbg_o  out  1  fetch_dbg_i
- resp_valid_i  in  1  OBI R-channel response valid
- resp_rdata_i  in  32  response data
- resp_err_i  in  1  response bus error
- out_valid_o  out  1  forwarded response valid; the consumer is always ready
- out_rdata_o  out  32  resp_rdata_i, passed through
- out_err_o  out  1  resp_err_i, passed through
- busy_o  out  1  outstanding count is non-zero
- discard_cnt_o  out  16  count of discarded responses (see Configuration)

## Operation
- Registers:
  - cnt_q: outstanding count, width $clog2(MAX_OUTSTANDING+1).
  - dcnt_q: responses still to discard, same width.
  - state_q: RUN or DISCARD.
- Issue: trans_valid_o = fetch_valid_i && !kill_i && (cnt_q < MAX_OUTSTANDING). Issue is purely combinational.
- Accept: a transaction counts as accepted on trans_valid_o && trans_ready_i. Any transaction the adapter accepts is guaranteed a response, so it is counted at acceptance.
- Count update: cnt_d = cnt_q + accept − resp_valid_i. Both events may occur in the same cycle (net 0). Overflow and underflow are illegal and are covered by assertions.
- Response routing:
  - When dcnt_q == 0 and kill_i == 0: out_valid_o = resp_valid_i.
  - Otherwise: out_valid_o = 0, and the response is dropped.
- Kill:
  - dcnt_d = cnt_q − resp_valid_i. A response arriving in the kill cycle is dropped.
  - No issue occurs in the kill cycle.
  - If dcnt_d is non-zero, state_q goes to DISCARD; otherwise it stays in RUN.
  - A kill while already in DISCARD recomputes dcnt in the same way.
- DISCARD state:
  - Each resp_valid_i decrements dcnt.
  - When dcnt reaches 0, state_q returns to RUN.
  - New fetches may issue in DISCARD, subject to the count limit. Their responses arrive after all older ones (OBI in-order), so they are forwarded.
- State transitions:
  - RUN → DISCARD: kill_i with dcnt_d > 0.
  - DISCARD → RUN: dcnt_d == 0.
  - A kill with cnt_q == 0 stays in RUN.
- busy_o = (cnt_q != 0).

## Timing
- Reset values: cnt_q = 0, dcnt_q = 0, state_q = RUN, discard_cnt = 0.
- Output values in reset: trans_valid_o = 0 while fetch_valid_i = 0, out_valid_o = 0 while resp_valid_i = 0, busy_o = 0.
- Issue path fetch_valid_i → trans_valid_o: 0 cycles (combinational).
- Response path resp_valid_i → out_valid_o: 0 cycles (combinational), no buffering.
- A slot freed by a response is usable on the next cycle only. At cnt_q == MAX, a response in the same cycle does not enable issue.
- Reset asserted mid-operation clears all counters immediately. The surrounding OBI adapter and bus are reset together, so no stale responses remain.

## Configuration
- CV32E40S_IFETCH_DISCARD_CNT_EN
  - Defined: discard_cnt_o is a 16-bit saturating counter incremented on every dropped response (kill-cycle drops included). It holds at 16'hFFFF and is cleared only by reset.
  - Undefined: discard_cnt_o is tied to 16'h0000 and no counter flops exist.

## Structure
- Shared package cv32e40s_pkg:
  - ifetch_seq_state_e {RUN, DISCARD}.
  - IFETCH_SEQ_MAX_OUTSTANDING_LIMIT = 7.
- Sub-module cv32e40s_ifetch_outstanding_cnt: generic up/down counter with inc, dec and load inputs and a zero flag. It is instantiated twice, once for cnt and once for dcnt.
- Assertions: no overflow of cnt_q, no resp_valid_i when cnt_q == 0, and addr[1:0] == 0 on the transaction interface.

## Test plan
- Back-to-back: fetch_valid_i = 1, trans_ready_i = 1, MAX = 2, responses 2 cycles after issue → at most 2 outstanding; trans_valid_o drops in the cycle cnt_q = 2; all 32'hxxxx data forwarded in order.
- Kill with 2 in flight: cnt_q = 2, kill_i pulses, then 2 responses → out_valid_o stays 0 for both; the third response (post-kill fetch to 0x100) is forwarded; state goes RUN → DISCARD → RUN.
- Kill coincident with a response: cnt_q = 2, kill_i and resp_valid_i in the same cycle → that response is dropped, dcnt = 1, the next response is dropped, and the following one is forwarded.
- Adapter stall: trans_ready_i = 0 for 5 cycles → cnt_q unchanged and fetch_ready_o = 0; on ready, cnt_q increments by 1.
- Error response: resp_err_i = 1 when not discarding → out_err_o = 1 with out_valid_o = 1; the same error during DISCARD is dropped.
- Macro on: 3 dropped responses → discard_cnt_o = 3. Macro off → discard_cnt_o = 0 throughout.
